// File: rtl/intdiv_seq_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package intdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned W_N_DEF   = 64;
  localparam int unsigned W_D_DEF   = 32;
  localparam int unsigned CNT_W_DEF = $clog2(W_N_DEF);

  // Cycles from acceptance to out_valid: one quotient bit per cycle.
  function automatic int unsigned intdiv_lat(input int unsigned w_n);
    return w_n;
  endfunction

  // Iteration counter width; never zero so a 1-bit dividend still elaborates.
  function automatic int unsigned intdiv_cnt_w(input int unsigned w_n);
    return (w_n > 1) ? $clog2(w_n) : 1;
  endfunction

endpackage

// File: rtl/intdiv_seq_if.sv
// Operand/result handshake bundle for intdiv_seq.
interface intdiv_seq_if #(
  parameter int unsigned W_N = 64,
  parameter int unsigned W_D = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W_N-1:0] N;
  logic [W_D-1:0] D;
  logic           out_valid;
  logic           out_ready;
  logic [W_N-1:0] Q;
  logic [W_D-1:0] R;
  logic           dz;

  modport master (
    output in_valid, N, D, out_ready,
    input  in_ready, out_valid, Q, R, dz
  );

  modport slave (
    input  in_valid, N, D, out_ready,
    output in_ready, out_valid, Q, R, dz
  );
endinterface

// File: rtl/intdiv_seq_step.sv
// One combinational restoring-division step; chainable for higher radix.
module intdiv_step #(
  parameter int unsigned W_D = 32
) (
  input  logic [W_D-1:0] r_i,
  input  logic           bit_i,
  input  logic [W_D-1:0] d_i,
  output logic [W_D-1:0] r_o,
  output logic           q_o
);
  logic [W_D:0] t;
  logic [W_D:0] dx;
  logic [W_D:0] diff;

  assign t    = {r_i, bit_i};
  assign dx   = {1'b0, d_i};
  assign diff = t - dx;
  assign q_o  = (t >= dx);

  // After a restore the remainder is below D, so W_D bits always hold it.
  assign r_o  = q_o ? W_D'(diff) : W_D'(t);
endmodule

// File: rtl/intdiv_seq.sv
// Radix-2 restoring unsigned divider: Q = N / D, R = N mod D, one bit per cycle.
module intdiv_seq
  import intdiv_pkg::*;
#(
  parameter int unsigned W_N = 64,
  parameter int unsigned W_D = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  intdiv_seq_if.slave  bus
);
  localparam int unsigned CNT_W = intdiv_cnt_w(W_N);

  state_e             state_q;
  logic [W_N-1:0]     shreg_q;
  logic [W_D-1:0]     div_q;
  logic [W_D-1:0]     r_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dz_q;
  logic               out_valid_q;

  logic [W_D-1:0]     step_r;
  logic               step_q;
  logic               accept;

  intdiv_step #(.W_D(W_D)) u_step (
    .r_i   (r_q),
    .bit_i (shreg_q[W_N-1]),
    .d_i   (div_q),
    .r_o   (step_r),
    .q_o   (step_q)
  );

  // Ready depends only on state and out_ready; held low while in reset.
  assign bus.in_ready = rst_n &&
                        ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.Q         = shreg_q;
  assign bus.R         = r_q;
  assign bus.dz        = dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      div_q       <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // Same load path from IDLE and from DONE-with-consumer-ready.
      state_q     <= CALC;
      shreg_q     <= bus.N;
      div_q       <= bus.D;
      r_q         <= '0;
      cnt_q       <= CNT_W'(W_N - 1);
      dz_q        <= (bus.D == '0);
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          shreg_q <= (shreg_q << 1) | W_N'(step_q);
          r_q     <= step_r;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        IDLE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intdiv_seq.sv
// Directed and random checks of intdiv_seq at 8/4 and 64/32 widths.
module tb_intdiv_seq;
  import intdiv_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } exp_t;

  exp_t sb8[$];
  exp_t sb64[$];

  intdiv_seq_if #(.W_N(8),  .W_D(4))  a ();
  intdiv_seq_if #(.W_N(64), .W_D(32)) b ();

  intdiv_seq #(.W_N(8),  .W_D(4))  u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  intdiv_seq #(.W_N(64), .W_D(32)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero gives all-ones and N's low bits.
  function automatic exp_t model(input logic [63:0] n, input logic [63:0] d,
                                 input int wn, input int wd);
    exp_t e;
    logic [63:0] mn;
    logic [63:0] md;
    mn = {64{1'b1}} >> (64 - wn);
    md = {64{1'b1}} >> (64 - wd);
    if ((d & md) == 64'd0) begin
      e.q  = mn;
      e.r  = n & md;
      e.dz = 1'b1;
    end else begin
      e.q  = (n & mn) / (d & md);
      e.r  = (n & mn) % (d & md);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] n, input logic [3:0] d);
    int k = 0;
    while (!a.in_ready && k < 100) begin tick(); k++; end
    chk("a_in_ready_wait", 64'(a.in_ready), 64'd1);
    a.in_valid = 1'b1; a.N = n; a.D = d;
    tick();
    a.in_valid = 1'b0;
    sb8.push_back(model(64'(n), 64'(d), 8, 4));
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (!a.out_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic check_out8(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(a.out_valid), 64'd1);
    if (sb8.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb8.pop_front();
      chk({tag, "_Q"},  64'(a.Q),  e.q);
      chk({tag, "_R"},  64'(a.R),  e.r);
      chk({tag, "_dz"}, 64'(a.dz), 64'(e.dz));
    end
  endtask

  task automatic release8();
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
    chk("a_released", 64'(a.out_valid), 64'd0);
  endtask

  task automatic div8(input string tag, input logic [7:0] n, input logic [3:0] d);
    int lat;
    issue8(n, d);
    wait_out8(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd8);
    check_out8(tag);
    release8();
  endtask

  task automatic div64(input logic [63:0] n, input logic [31:0] d);
    int   k = 0;
    int   lat = 0;
    exp_t e;
    while (!b.in_ready && k < 100) begin tick(); k++; end
    chk("b_in_ready_wait", 64'(b.in_ready), 64'd1);
    b.in_valid = 1'b1; b.N = n; b.D = d;
    tick();
    b.in_valid = 1'b0;
    sb64.push_back(model(n, 64'(d), 64, 32));
    while (!b.out_valid && lat < 300) begin tick(); lat++; end
    chk("b_lat", 64'(lat), 64'd64);
    if (sb64.size() == 0) begin
      chk("b_sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb64.pop_front();
      chk("b_Q",  b.Q,        e.q);
      chk("b_R",  64'(b.R),   e.r);
      chk("b_dz", 64'(b.dz),  64'(e.dz));
    end
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    exp_t e;
    rst_n = 1'b0;
    a.in_valid = 1'b0; a.N = '0; a.D = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.N = '0; b.D = '0; b.out_ready = 1'b0;

    #12;
    chk("rst_in_ready",  64'(a.in_ready),  64'd0);
    chk("rst_out_valid", 64'(a.out_valid), 64'd0);
    chk("rst_Q",         64'(a.Q),         64'd0);
    chk("rst_R",         64'(a.R),         64'd0);
    chk("rst_dz",        64'(a.dz),        64'd0);
    chk("rst_b_ready",   64'(b.in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(a.in_ready), 64'd1);

    div8("d100_7",  8'd100, 4'd7);
    div8("d3_15",   8'd3,   4'd15);
    div8("d200_0",  8'd200, 4'd0);

    // Backpressure: hold the result, then chain a new pair in the release cycle.
    issue8(8'd255, 4'd15);
    wait_out8(lat);
    chk("bp_lat", 64'(lat), 64'd8);
    e = model(64'd255, 64'd15, 8, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_Q_hold",  64'(a.Q),         e.q);
      chk("bp_R_hold",  64'(a.R),         e.r);
      chk("bp_ready",   64'(a.in_ready),  64'd0);
      chk("bp_valid",   64'(a.out_valid), 64'd1);
    end
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1; a.N = 8'd9; a.D = 4'd2;
    #1;
    chk("b2b_ready", 64'(a.in_ready), 64'd1);
    check_out8("d255_15");
    tick();
    a.in_valid  = 1'b0;
    a.out_ready = 1'b0;
    sb8.push_back(model(64'd9, 64'd2, 8, 4));
    chk("b2b_valid_drop", 64'(a.out_valid), 64'd0);
    wait_out8(lat);
    chk("b2b_lat", 64'(lat), 64'd8);
    check_out8("d9_2");
    release8();

    // Reset in the middle of a division discards it.
    issue8(8'd77, 4'd3);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(a.out_valid), 64'd0);
    chk("midrst_ready", 64'(a.in_ready),  64'd0);
    sb8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_ready_rel", 64'(a.in_ready), 64'd1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a.out_valid) lat++;
    end
    chk("midrst_no_emit", 64'(lat), 64'd0);
    div8("d50_5", 8'd50, 4'd5);

    // Wide configuration: corner divisors, then random pairs.
    div64({$urandom, $urandom}, 32'd1);
    div64({$urandom, $urandom}, 32'hFFFF_FFFF);
    div64(64'd5, 32'd1000);
    div64(64'hFFFF_FFFF_FFFF_FFFF, 32'd1);
    div64(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    div64(64'd0, 32'd7);
    div64(64'h1234_5678_9ABC_DEF0, 32'd0);
    div64(64'hFFFF_FFFE, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] dv;
      dv = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      div64({$urandom, $urandom}, dv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intdiv_seq.md
# intdiv_seq

Sequential radix-2 restoring unsigned integer divider: the inverse of the integer multiplier. Computes Q = N / D and R = N mod D for a W_N-bit dividend and W_D-bit divisor, one quotient bit per cycle, behind valid/ready handshakes on both sides. It sits beside the integer multipliers in the modular-arithmetic datapath and serves quotient-estimate and reduction-constant paths where DSP-based multiplication is not applicable.

## Interface
- Reset is decided: one clock; reset is asynchronous and active-low.
- W_N, 64, dividend and quotient width (product width of a W_A×W_B multiply).
- W_D, 32, divisor and remainder width; 1 ≤ W_D ≤ W_N.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  N and D are valid.
- in_ready  out  1  divider accepts an operand pair.
- N  in  W_N  dividend, unsigned.
- D  in  W_D  divisor, unsigned.
- out_valid  out  1  Q, R and dz are valid.
- out_ready  in  1  consumer accepts the result.
- Q  out  W_N  quotient.
- R  out  W_D  remainder.
- dz  out  1  divisor was zero.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch N into the quotient/dividend shift register, D into the divisor register, clear the W_D+1-bit partial remainder r, set iteration counter to W_N-1, set dz = (D==0), go to CALC.
- CALC, one step per cycle: t = {r[W_D-1:0], msb of shift reg}; if t ≥ {1'b0,D} then r = t − D and shift in 1, else r = t and shift in 0. Counter decrements; the step with counter==0 is the last → DONE.
- DONE: out_valid=1; Q = shift register, R = r[W_D-1:0]. Outputs hold stable until out_ready.
- DONE with out_ready=1: if in_valid=1, accept the new pair in the same cycle (in_ready=1) and go to CALC; else go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). No combinational path from in_valid to in_ready.
- D==0: no special path; the algorithm naturally yields Q = all ones and R = N[W_D-1:0]; dz=1. Latency is unchanged.
- Width rule: r needs W_D+1 bits, since t < 2·D ≤ 2^(W_D+1). The comparator/subtractor is W_D+1 bits wide.
- Reset mid-operation: the in-flight division is discarded, the state returns to IDLE, and nothing is emitted.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 in the first cycle after release; out_valid=0, Q=0, R=0, dz=0.
- Latency: an operand pair accepted at edge t gives out_valid=1 after edge t+W_N (W_N CALC cycles, then DONE).
- Throughput: one division per W_N+1 cycles with out_ready held high (DONE→CALC back-to-back); one per W_N+2 cycles via IDLE.
- out_valid, Q, R and dz are registered. in_ready is a function of state and out_ready only.

## Structure
- intdiv_pkg holds:
  - the typedef enum for IDLE/CALC/DONE,
  - function intdiv_lat(W_N), which returns W_N,
  - the counter width constant $clog2(W_N).
- The sub-module intdiv_step is a combinational single restoring step: inputs r, the incoming bit and D; outputs r' and the q bit. It is parameterised by W_D so that a later radix-4 variant can chain two instances.

## Test plan
- W_N=8, W_D=4: N=100, D=7 → Q=14, R=2, dz=0, out_valid exactly 8 cycles after acceptance.
- N=255, D=15 → Q=17, R=0; N=3, D=15 → Q=0, R=3.
- N=200, D=0 → Q=255, R=8, dz=1, same latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Q/R stable and in_ready=0; then out_ready=1 with in_valid=1 (N=9, D=2) → accepted that cycle, next result Q=4, R=1 after 9 further edges.
- Reset: deassert rst_n at CALC step 3 → out_valid stays 0 and in_ready=1 after release; the next division (N=50, D=5 → Q=10, R=0) is correct.
- Random regression at W_N=64, W_D=32, including D=1, D=2^32−1 and N<D, against a reference model of N/D and N%D.
